hazard_ctrl: RTL and testbench

Pipeline interlock controller: the producer-side counterpart of the forwarding unit. It decides when forwarding cannot supply an operand and the pipeline must stall or insert a bubble. It tracks load-use hazards against the DC_ALU stage and keeps a register scoreboard for long-latency ops (mul/div) whose results arrive out of band. It sits beside the decode stage, drives the IF/DC stall and DC_ALU bubble controls, and takes branch flushes from the ALU.

---
 rtl/hazard_ctrl_pkg.sv | 33 +++
 rtl/hazard_scoreboard.sv | 69 ++++++
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline interlock
// controller.
//   REG_ADDR_W   : register address width (x0..x31)
//   HZ_W         : width of the registered stall-reason bus
//   hz_state_e   : stall reason, HZ_RUN/HZ_LD/HZ_SB/HZ_ST
//   hz_cause_t   : raw hazard flags raised in the current cycle
//   hz_reason()  : priority encode of the flags, LD > SB > ST
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int HZ_W       = 2;

  typedef enum logic [HZ_W-1:0] {
    HZ_RUN = 2'd0,
    HZ_LD  = 2'd1,
    HZ_SB  = 2'd2,
    HZ_ST  = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic ld;
    logic sb;
    logic st;
  } hz_cause_t;

  function automatic hz_state_e hz_reason(input hz_cause_t c);
    if (c.ld)      return HZ_LD;
    else if (c.sb) return HZ_SB;
    else if (c.st) return HZ_ST;
    else           return HZ_RUN;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending-write bit per architectural register plus the
// busy flag of the single long-latency unit.
//   clk, rst_n       : clock, async active-low reset
//   issue_i          : long op leaves decode this cycle
//   issue_wen_i      : issuing op writes issue_rd_i
//   issue_rd_i       : destination of the issuing op
//   done_i, done_rd_i: long unit writes back done_rd_i this cycle
//   rs1_i/rs2_i/rd_i : read-port addresses from decode
//   pending_o        : full scoreboard vector
//   long_busy_o      : long unit occupied
//   rs1_pend_o ...   : scoreboard bit of each read port
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_i,
  input  logic                  issue_wen_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  done_i,
  input  logic [REG_ADDR_W-1:0] done_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic [REG_NUM-1:0]    pending_o,
  output logic                  long_busy_o,
  output logic                  rs1_pend_o,
  output logic                  rs2_pend_o,
  output logic                  rd_pend_o
);

  logic [REG_NUM-1:0] pend_q, pend_d;
  logic [REG_NUM-1:0] set_vec, clr_vec;
  logic               busy_q, busy_d;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_i && issue_wen_i && (issue_rd_i != '0))
      set_vec = REG_NUM'(1) << issue_rd_i;
    if (done_i)
      clr_vec = REG_NUM'(1) << done_rd_i;
    // set applied after clear so a same-register reissue keeps the bit;
    // bit 0 masked since x0 can never be outstanding
    pend_d    = ((pend_q & ~clr_vec) | set_vec) & ~REG_NUM'(1);
    busy_d    = issue_i ? 1'b1 : (done_i ? 1'b0 : busy_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      busy_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  // reads use the registered vector: a register completing this cycle is
  // still reported pending until the regfile holds its value
  assign pending_o   = pend_q;
  assign long_busy_o = busy_q;
  assign rs1_pend_o  = pend_q[rs1_i];
  assign rs2_pend_o  = pend_q[rs2_i];
  assign rd_pend_o   = pend_q[rd_i];

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock controller beside the decode stage.
// Detects load-use, scoreboard (RAW/WAW on long ops) and long-unit
// structural hazards, drives IF/DC stall and DC_ALU bubble, applies branch
// flushes, dispatches long ops into the scoreboard.
//   clk, rst_n                  : clock, async active-low reset
//   dc_*                        : decode-stage instruction fields
//   ex_valid/ex_is_load/ex_rd   : instruction in DC_ALU
//   lu_done/lu_rd               : long-unit writeback
//   branch_flush                : taken branch/jump from ALU
//   stall_fetch/stall_decode    : hold PC, IF/DC and DC contents
//   bubble_alu/flush_decode     : NOP into DC_ALU, squash DC
//   lu_issue                    : long op dispatched this cycle
//   sb_pending                  : scoreboard vector
//   hz_state                    : registered stall reason
//   stall_cnt                   : saturating stalled-cycle count
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dc_valid,
  input  logic [REG_ADDR_W-1:0] dc_rs1,
  input  logic [REG_ADDR_W-1:0] dc_rs2,
  input  logic                  dc_rs1_used,
  input  logic                  dc_rs2_used,
  input  logic [REG_ADDR_W-1:0] dc_rd,
  input  logic                  dc_rd_wen,
  input  logic                  dc_is_long,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  lu_done,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic                  branch_flush,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  bubble_alu,
  output logic                  flush_decode,
  output logic                  lu_issue,
  output logic [REG_NUM-1:0]    sb_pending,
  output logic [HZ_W-1:0]       hz_state,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic      long_busy;
  logic      rs1_pend, rs2_pend, rd_pend;
  hz_cause_t cause;
  logic      stall;

  hz_state_e        hz_state_q, hz_state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  hazard_scoreboard #(.REG_NUM(REG_NUM)) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_i     (lu_issue),
    .issue_wen_i (dc_rd_wen),
    .issue_rd_i  (dc_rd),
    .done_i      (lu_done),
    .done_rd_i   (lu_rd),
    .rs1_i       (dc_rs1),
    .rs2_i       (dc_rs2),
    .rd_i        (dc_rd),
    .pending_o   (sb_pending),
    .long_busy_o (long_busy),
    .rs1_pend_o  (rs1_pend),
    .rs2_pend_o  (rs2_pend),
    .rd_pend_o   (rd_pend)
  );

  always_comb begin
    cause.ld = ex_valid && ex_is_load && (ex_rd != '0) &&
               ((dc_rs1_used && (dc_rs1 == ex_rd)) ||
                (dc_rs2_used && (dc_rs2 == ex_rd)));
    cause.sb = (dc_rs1_used && (dc_rs1 != '0) && rs1_pend) ||
               (dc_rs2_used && (dc_rs2 != '0) && rs2_pend) ||
               (dc_rd_wen   && (dc_rd  != '0) && rd_pend);
    // a writeback this cycle frees the unit for an immediate reissue
    cause.st = dc_is_long && long_busy && !lu_done;
  end

  assign stall        = dc_valid && (cause.ld || cause.sb || cause.st) && !branch_flush;
  assign stall_fetch  = stall;
  assign stall_decode = stall;
  assign bubble_alu   = stall || branch_flush;
  assign flush_decode = branch_flush;
  assign lu_issue     = dc_valid && dc_is_long && !stall && !branch_flush;

  always_comb begin
    hz_state_d  = stall ? hz_reason(cause) : HZ_RUN;
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_state_q  <= HZ_RUN;
      stall_cnt_q <= '0;
    end else begin
      hz_state_q  <= hz_state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz_state  = hz_state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic dc_valid, dc_rs1_used, dc_rs2_used, dc_rd_wen, dc_is_long;
  logic [4:0] dc_rs1, dc_rs2, dc_rd, ex_rd, lu_rd;
  logic ex_valid, ex_is_load, lu_done, branch_flush;
  logic stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue;
  logic [31:0] sb_pending;
  logic [1:0]  hz_state;
  logic [CW-1:0] stall_cnt;

  int vecs = 0, errs = 0;

  hazard_ctrl #(.REG_NUM(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .dc_valid(dc_valid), .dc_rs1(dc_rs1), .dc_rs2(dc_rs2),
    .dc_rs1_used(dc_rs1_used), .dc_rs2_used(dc_rs2_used), .dc_rd(dc_rd),
    .dc_rd_wen(dc_rd_wen), .dc_is_long(dc_is_long), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .lu_done(lu_done), .lu_rd(lu_rd),
    .branch_flush(branch_flush), .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .bubble_alu(bubble_alu), .flush_decode(flush_decode), .lu_issue(lu_issue),
    .sb_pending(sb_pending), .hz_state(hz_state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [31:0]     m_pend;
  bit            m_busy;
  logic [1:0]    m_hz;
  logic [CW-1:0] m_cnt;

  function automatic bit m_ld();
    return ex_valid && ex_is_load && ex_rd != 0 &&
           ((dc_rs1_used && dc_rs1 == ex_rd) || (dc_rs2_used && dc_rs2 == ex_rd));
  endfunction
  function automatic bit m_sb();
    return (dc_rs1_used && dc_rs1 != 0 && m_pend[dc_rs1]) ||
           (dc_rs2_used && dc_rs2 != 0 && m_pend[dc_rs2]) ||
           (dc_rd_wen && dc_rd != 0 && m_pend[dc_rd]);
  endfunction
  function automatic bit m_st();
    return dc_is_long && m_busy && !lu_done;
  endfunction
  function automatic bit m_stall();
    return dc_valid && (m_ld() || m_sb() || m_st()) && !branch_flush;
  endfunction
  function automatic bit m_issue();
    return dc_valid && dc_is_long && !m_stall() && !branch_flush;
  endfunction
  // {stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue}
  function automatic logic [4:0] exp_comb();
    bit s;
    s = m_stall();
    return {s, s, s | branch_flush, branch_flush, m_issue()};
  endfunction
  function automatic logic [31:0] next_pend();
    bit [31:0] p;
    p = m_pend;
    if (lu_done) p[lu_rd] = 1'b0;
    if (m_issue() && dc_rd_wen && dc_rd != 0) p[dc_rd] = 1'b1;
    return p;
  endfunction
  function automatic logic [1:0] next_hz();
    if (!m_stall()) return 2'd0;
    if (m_ld()) return 2'd1;
    if (m_sb()) return 2'd2;
    return 2'd3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= '0; m_busy <= 1'b0; m_hz <= 2'd0; m_cnt <= '0;
    end else begin
      m_pend <= next_pend();
      m_busy <= m_issue() ? 1'b1 : (lu_done ? 1'b0 : m_busy);
      m_hz   <= next_hz();
      if (m_stall() && m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    dc_valid = 0; dc_rs1 = 0; dc_rs2 = 0; dc_rs1_used = 0; dc_rs2_used = 0;
    dc_rd = 0; dc_rd_wen = 0; dc_is_long = 0; ex_valid = 0; ex_is_load = 0;
    ex_rd = 0; lu_done = 0; lu_rd = 0; branch_flush = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0; #2; rst_n = 1; #1;
  endtask

  task automatic long_op(input logic [4:0] rd, input logic wen);
    set_idle();
    dc_valid = 1; dc_is_long = 1; dc_rd = rd; dc_rd_wen = wen;
  endtask

  task automatic reader(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    set_idle();
    dc_valid = 1; dc_rs1 = rs1; dc_rs2 = rs2; dc_rs1_used = 1; dc_rs2_used = 1;
    dc_rd = rd; dc_rd_wen = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    rst_n = 0;
    tick();
    vecs++;
    if ({sb_pending, hz_state, stall_cnt} !== '0) begin
      errs++; $display("FAIL reset_state: got pend=%h hz=%0d cnt=%0d want 0/0/0", sb_pending, hz_state, stall_cnt);
    end
    vecs++;
    if ({stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue} !== 5'b0) begin
      errs++; $display("FAIL reset_comb: got %b want 00000", {stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue});
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    reader(5'd5, 5'd1, 5'd10); dc_rs2_used = 0;
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5;
    #1; vecs++;
    if ({stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue} !== 5'b11100) begin
      errs++; $display("FAIL load_use_stall: got %b want 11100", {stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue});
    end
    tick();
    ex_valid = 0; ex_is_load = 0;
    #1; vecs++;
    if ({hz_state, stall_cnt, stall_fetch, bubble_alu} !== {HZ_LD, 4'd1, 2'b00}) begin
      errs++; $display("FAIL load_use_after: got hz=%0d cnt=%0d sf=%b bub=%b want 1/1/0/0", hz_state, stall_cnt, stall_fetch, bubble_alu);
    end
    tick();
  endtask

  task automatic test_long_dep();
    do_reset();
    long_op(5'd7, 1'b1);
    #1; vecs++;
    if ({stall_fetch, lu_issue} !== 2'b01) begin
      errs++; $display("FAIL long_issue: got stall=%b issue=%b want 0/1", stall_fetch, lu_issue);
    end
    tick();
    vecs++;
    if (sb_pending !== 32'h80) begin
      errs++; $display("FAIL sb_set7: got %h want 00000080", sb_pending);
    end
    reader(5'd7, 5'd2, 5'd8);
    for (int i = 0; i < 3; i++) begin
      #1; vecs++;
      if ({stall_fetch, stall_decode, bubble_alu} !== 3'b111) begin
        errs++; $display("FAIL dep_stall cyc%0d: got %b want 111", i, {stall_fetch, stall_decode, bubble_alu});
      end
      tick();
    end
    lu_done = 1; lu_rd = 5'd7;
    #1; vecs++;
    if ({stall_fetch, lu_issue} !== 2'b10) begin
      errs++; $display("FAIL dep_stall_done_cycle: got stall=%b issue=%b want 1/0", stall_fetch, lu_issue);
    end
    tick();
    lu_done = 0;
    #1; vecs++;
    if ({sb_pending, hz_state, stall_cnt, stall_fetch} !== {32'h0, HZ_SB, 4'd4, 1'b0}) begin
      errs++; $display("FAIL dep_release: got pend=%h hz=%0d cnt=%0d stall=%b want 0/2/4/0", sb_pending, hz_state, stall_cnt, stall_fetch);
    end
    tick();
  endtask

  task automatic test_structural();
    do_reset();
    long_op(5'd3, 1'b0);
    tick();
    long_op(5'd3, 1'b1);
    #1; vecs++;
    if ({stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue} !== 5'b11100) begin
      errs++; $display("FAIL struct_stall: got %b want 11100", {stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue});
    end
    tick();
    vecs++;
    if (hz_state !== HZ_ST) begin
      errs++; $display("FAIL struct_hz: got %0d want 3", hz_state);
    end
    lu_done = 1; lu_rd = 5'd3;
    #1; vecs++;
    if ({stall_fetch, lu_issue} !== 2'b01) begin
      errs++; $display("FAIL struct_reissue: got stall=%b issue=%b want 0/1", stall_fetch, lu_issue);
    end
    tick();
    lu_done = 0; set_idle();
    vecs++;
    if (sb_pending !== 32'h8) begin
      errs++; $display("FAIL set_wins: got %h want 00000008", sb_pending);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    long_op(5'd6, 1'b1);
    dc_rs1 = 5'd4; dc_rs1_used = 1;
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd4; branch_flush = 1;
    #1; vecs++;
    if ({stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue} !== 5'b00110) begin
      errs++; $display("FAIL flush_prio: got %b want 00110", {stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue});
    end
    tick();
    set_idle();
    vecs++;
    if ({sb_pending, hz_state, stall_cnt} !== '0) begin
      errs++; $display("FAIL flush_state: got pend=%h hz=%0d cnt=%0d want 0/0/0", sb_pending, hz_state, stall_cnt);
    end
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    long_op(5'd0, 1'b1);
    #1; vecs++;
    if (lu_issue !== 1'b1) begin
      errs++; $display("FAIL x0_issue: got %b want 1", lu_issue);
    end
    tick();
    vecs++;
    if (sb_pending !== 32'h0) begin
      errs++; $display("FAIL x0_pending: got %h want 0", sb_pending);
    end
    reader(5'd0, 5'd0, 5'd0);
    #1; vecs++;
    if ({stall_fetch, bubble_alu} !== 2'b00) begin
      errs++; $display("FAIL x0_nostall: got %b want 00", {stall_fetch, bubble_alu});
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    long_op(5'd9, 1'b1);
    tick();
    reader(5'd9, 5'd1, 5'd2);
    vecs++;
    if (sb_pending !== 32'h200) begin
      errs++; $display("FAIL ar_set9: got %h want 00000200", sb_pending);
    end
    tick();
    #2; rst_n = 0; #1;
    vecs++;
    if ({sb_pending, hz_state, stall_cnt, stall_fetch} !== '0) begin
      errs++; $display("FAIL async_reset: got pend=%h hz=%0d cnt=%0d stall=%b want all 0", sb_pending, hz_state, stall_cnt, stall_fetch);
    end
    #1; rst_n = 1;
    set_idle();
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    reader(5'd12, 5'd1, 5'd2);
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd12;
    repeat (20) tick();
    vecs++;
    if (stall_cnt !== {CW{1'b1}}) begin
      errs++; $display("FAIL cnt_saturate: got %0d want %0d", stall_cnt, {CW{1'b1}});
    end
    set_idle();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      dc_valid     = ($urandom_range(0, 7) != 0);
      dc_rs1       = 5'($urandom_range(0, 7));
      dc_rs2       = 5'($urandom_range(0, 7));
      dc_rs1_used  = $urandom_range(0, 1);
      dc_rs2_used  = $urandom_range(0, 1);
      dc_rd        = 5'($urandom_range(0, 7));
      dc_rd_wen    = $urandom_range(0, 1);
      dc_is_long   = ($urandom_range(0, 2) == 0);
      ex_valid     = $urandom_range(0, 1);
      ex_is_load   = $urandom_range(0, 1);
      ex_rd        = 5'($urandom_range(0, 7));
      lu_done      = m_busy && ($urandom_range(0, 2) == 0);
      lu_rd        = 5'($urandom_range(0, 7));
      branch_flush = ($urandom_range(0, 9) == 0);
      if (n % 100 == 99) begin
        // keep the saturating counter below all-ones for a while
        rst_n = 0; #1; rst_n = 1;
      end
      #1; vecs++;
      if ({stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue} !== exp_comb()) begin
        errs++; $display("FAIL rand_comb n=%0d: got %b want %b", n, {stall_fetch, stall_decode, bubble_alu, flush_decode, lu_issue}, exp_comb());
      end
      vecs++;
      if ({sb_pending, hz_state, stall_cnt} !== {m_pend, m_hz, m_cnt}) begin
        errs++; $display("FAIL rand_state n=%0d: got pend=%h hz=%0d cnt=%0d want pend=%h hz=%0d cnt=%0d",
                         n, sb_pending, hz_state, stall_cnt, m_pend, m_hz, m_cnt);
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_long_dep();
    test_structural();
    test_flush();
    test_x0();
    test_async_reset();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, vectors=%0d", vecs);
    $fatal(1);
  end

endmodule
